// File: rtl/wb_sram16_bridge.sv
// Wishbone classic slave bridging 32-bit accesses onto a 16-bit async SRAM, high halfword first.
// Optional macro SRAM_ADDR_CHECK_EN: out-of-range requests get a one-cycle wb_err_o instead of aliasing.
module wb_sram16_bridge #(
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clock_50,
    input  logic               reset,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [15:0]        sram_dq,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_lb_n,
    output logic               sram_ub_n
);

    typedef enum logic [2:0] {
        IDLE, H_ACC, H_REC, L_ACC, L_REC, ACK, ERR
    } state_t;

    state_t state, next_state;

    logic [SRAM_AW-2:0] word_q, word_e;
    logic [31:0]        dat_q, dat_e;
    logic [3:0]         sel_q, sel_e;
    logic               we_q, we_e;
    logic               abort_q;
    logic [3:0]         cnt;
    logic               acc_done;
    logic               req, in_idle, in_acc, addr_bad;
    logic [15:0]        dq_out, n_dq_out;
    logic               dq_oe, n_dq_oe;
    logic               n_ce_n, n_oe_n, n_we_n, n_lb_n, n_ub_n;
    logic [SRAM_AW-1:0] n_addr;
    logic               is_h, is_l, is_acc;

    assign req      = wb_cyc_i & wb_stb_i;
    assign in_idle  = (state == IDLE);
    assign in_acc   = (state == H_ACC) || (state == L_ACC);
    assign acc_done = (cnt == 4'(WAIT_CYCLES - 1));

`ifdef SRAM_ADDR_CHECK_EN
    logic unused_adr_bits;
    assign unused_adr_bits = ^wb_adr_i[1:0];
    assign addr_bad = |wb_adr_i[31:SRAM_AW+1];
`else
    logic unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:SRAM_AW+1], wb_adr_i[1:0]};
    assign addr_bad = 1'b0;
`endif

    // Output registers are loaded from next-state decode, so request fields must bypass the latches in IDLE.
    assign word_e = in_idle ? wb_adr_i[SRAM_AW:2] : word_q;
    assign dat_e  = in_idle ? wb_dat_i : dat_q;
    assign sel_e  = in_idle ? wb_sel_i : sel_q;
    assign we_e   = in_idle ? wb_we_i  : we_q;

    assign sram_dq = dq_oe ? dq_out : 'z;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (addr_bad)                 next_state = ERR;
                    else if (wb_sel_i == 4'b0000) next_state = ACK;
                    else if (wb_sel_i[3:2] == '0) next_state = L_ACC;
                    else                          next_state = H_ACC;
                end
            end
            H_ACC:   if (acc_done) next_state = H_REC;
            H_REC: begin
                if (abort_q)          next_state = IDLE;
                else if (|sel_q[1:0]) next_state = L_ACC;
                else                  next_state = ACK;
            end
            L_ACC:   if (acc_done) next_state = L_REC;
            L_REC:   next_state = abort_q ? IDLE : ACK;
            ACK:     next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        is_h     = (next_state == H_ACC) || (next_state == H_REC);
        is_l     = (next_state == L_ACC) || (next_state == L_REC);
        is_acc   = (next_state == H_ACC) || (next_state == L_ACC);
        n_ce_n   = ~(is_h | is_l);
        n_oe_n   = ~(is_acc & ~we_e);
        n_we_n   = ~(is_acc & we_e);
        n_ub_n   = 1'b1;
        n_lb_n   = 1'b1;
        n_addr   = sram_addr;
        n_dq_out = dq_out;
        n_dq_oe  = (is_h | is_l) & we_e;
        if (is_h) begin
            n_ub_n   = ~sel_e[3];
            n_lb_n   = ~sel_e[2];
            n_addr   = {word_e, 1'b0};
            n_dq_out = dat_e[31:16];
        end else if (is_l) begin
            n_ub_n   = ~sel_e[1];
            n_lb_n   = ~sel_e[0];
            n_addr   = {word_e, 1'b1};
            n_dq_out = dat_e[15:0];
        end
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            word_q    <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            abort_q   <= 1'b0;
            wb_dat_o  <= '0;
            wb_ack_o  <= 1'b0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= (in_acc && next_state == state) ? cnt + 4'd1 : '0;
            if (in_idle && req) begin
                word_q   <= wb_adr_i[SRAM_AW:2];
                dat_q    <= wb_dat_i;
                sel_q    <= wb_sel_i;
                we_q     <= wb_we_i;
                abort_q  <= 1'b0;
                wb_dat_o <= '0;
            end else if (in_acc) begin
                abort_q <= abort_q | ~wb_cyc_i;
            end
            if (state == H_ACC && acc_done && !we_q)
                wb_dat_o[31:16] <= {sel_q[3] ? sram_dq[15:8] : 8'h00, sel_q[2] ? sram_dq[7:0] : 8'h00};
            if (state == L_ACC && acc_done && !we_q)
                wb_dat_o[15:0] <= {sel_q[1] ? sram_dq[15:8] : 8'h00, sel_q[0] ? sram_dq[7:0] : 8'h00};
            wb_ack_o  <= (next_state == ACK);
            sram_addr <= n_addr;
            sram_ce_n <= n_ce_n;
            sram_oe_n <= n_oe_n;
            sram_we_n <= n_we_n;
            sram_lb_n <= n_lb_n;
            sram_ub_n <= n_ub_n;
            dq_out    <= n_dq_out;
            dq_oe     <= n_dq_oe;
        end
    end

`ifdef SRAM_ADDR_CHECK_EN
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) wb_err_o <= 1'b0;
        else       wb_err_o <= (next_state == ERR);
    end
`else
    assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sram16_bridge.sv
// Bench for wb_sram16_bridge: W=1 instance driven by a vector table, W=3 instance for stretched timing.
// Error-response expectations follow SRAM_ADDR_CHECK_EN.
module tb_wb_sram16_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr, wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic [1:0]  cyc, stb, ack, err;
    logic [31:0] dat_o [2];
    logic [17:0] addr0, addr1;
    logic [1:0]  ce_n, oe_n, we_n, lb_n, ub_n;
    wire  [15:0] dq0, dq1;

    logic [15:0] mem0 [256];
    logic [15:0] mem1 [256];
    int ce_low [2];
    int bad_cnt = 0;
    int run1 = 0, last_run1 = 0, prev_run1 = 0, n_runs1 = 0;
    int checks = 0, errors = 0;

    always #10 clk = ~clk;

    wb_sram16_bridge #(.SRAM_AW(18), .WAIT_CYCLES(1)) dut0 (
        .clock_50(clk), .reset(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(dat_o[0]),
        .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
        .wb_ack_o(ack[0]), .wb_err_o(err[0]), .sram_addr(addr0), .sram_dq(dq0),
        .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]),
        .sram_lb_n(lb_n[0]), .sram_ub_n(ub_n[0]));

    wb_sram16_bridge #(.SRAM_AW(18), .WAIT_CYCLES(3)) dut1 (
        .clock_50(clk), .reset(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(dat_o[1]),
        .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
        .wb_ack_o(ack[1]), .wb_err_o(err[1]), .sram_addr(addr1), .sram_dq(dq1),
        .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]),
        .sram_lb_n(lb_n[1]), .sram_ub_n(ub_n[1]));

    // Async SRAM models: drive on a read, latch selected lanes while WE_N is low.
    assign dq0 = (!ce_n[0] && !oe_n[0] && we_n[0]) ? mem0[addr0[7:0]] : 16'hzzzz;
    assign dq1 = (!ce_n[1] && !oe_n[1] && we_n[1]) ? mem1[addr1[7:0]] : 16'hzzzz;

    always @(negedge clk) begin
        if (!ce_n[0] && !we_n[0]) begin
            if (!lb_n[0]) mem0[addr0[7:0]][7:0]  <= dq0[7:0];
            if (!ub_n[0]) mem0[addr0[7:0]][15:8] <= dq0[15:8];
        end
        if (!ce_n[1] && !we_n[1]) begin
            if (!lb_n[1]) mem1[addr1[7:0]][7:0]  <= dq1[7:0];
            if (!ub_n[1]) mem1[addr1[7:0]][15:8] <= dq1[15:8];
        end
        if ((!oe_n[0] && !we_n[0]) || (!oe_n[1] && !we_n[1])) bad_cnt <= bad_cnt + 1;
        if (!ce_n[0]) ce_low[0] <= ce_low[0] + 1;
        if (!ce_n[1]) ce_low[1] <= ce_low[1] + 1;
        if (!oe_n[1]) begin
            run1 <= run1 + 1;
        end else if (run1 != 0) begin
            prev_run1 <= last_run1;
            last_run1 <= run1;
            n_runs1   <= n_runs1 + 1;
            run1      <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic inst, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rd, output int lat,
                        output logic got_ack, output logic got_err, output int ce_cycles);
        int ce_start;
        @(negedge clk);
        wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we;
        cyc[inst] = 1'b1; stb[inst] = 1'b1;
        ce_start = ce_low[inst];
        @(posedge clk); #1;
        lat = 1;
        while (!ack[inst] && !err[inst] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got_ack   = ack[inst];
        got_err   = err[inst];
        rd        = dat_o[inst];
        ce_cycles = ce_low[inst] - ce_start;
        cyc[inst] = 1'b0; stb[inst] = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_ce;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        logic [31:0] rd;
        int          lat, cec;
        logic        a, e, seen;

        vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        5, 4};
        vecs[1]  = '{1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADBEEF, 5, 4};
        vecs[2]  = '{1'b1, 32'h10, 32'h0000AA00, 4'h2, 32'h0,        3, 2};
        vecs[3]  = '{1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADAAEF, 5, 4};
        vecs[4]  = '{1'b0, 32'h10, 32'h0,        4'hC, 32'hDEAD0000, 3, 2};
        vecs[5]  = '{1'b0, 32'h10, 32'h0,        4'h0, 32'h0,        1, 0};
        vecs[6]  = '{1'b0, 32'h13, 32'h0,        4'h1, 32'h000000EF, 3, 2};
        vecs[7]  = '{1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 32'h0,        5, 4};
        vecs[8]  = '{1'b1, 32'h20, 32'h12345678, 4'h9, 32'h0,        5, 4};
        vecs[9]  = '{1'b0, 32'h20, 32'h0,        4'hF, 32'h12BBCC78, 5, 4};
        vecs[10] = '{1'b0, 32'h22, 32'h0,        4'h6, 32'h00BBCC00, 5, 4};

        rst = 1'b1; cyc = '0; stb = '0;
        wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", 64'({ce_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0], ack[0], err[0]}), 64'h7C);
        chk("reset_addr", 64'(addr0), 64'h0);
        chk("reset_dat", 64'(dat_o[0]), 64'h0);
        rst = 1'b0;

        for (int unsigned i = 0; i < NV; i++) begin
            xfer(1'b0, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, lat, a, e, cec);
            chk($sformatf("vec%0d_ack", i), 64'(a), 64'h1);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_ce_cycles", i), 64'(cec), 64'(vecs[i].exp_ce));
            if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
        end
        chk("mem8", 64'(mem0[8]), 64'hDEAD);
        chk("mem9", 64'(mem0[9]), 64'hAAEF);
        chk("mem16", 64'(mem0[16]), 64'h12BB);
        chk("mem17", 64'(mem0[17]), 64'hCC78);

        // Abort: drop the cycle during the high-half write.
        @(negedge clk);
        wb_adr = 32'h10; wb_dat = 32'hCAFEF00D; wb_sel = 4'hF; wb_we = 1'b1;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        @(posedge clk); #1;
        cyc[0] = 1'b0; stb[0] = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack[0]) seen = 1'b1;
        end
        chk("abort_no_ack", 64'(seen), 64'h0);
        chk("abort_mem8", 64'(mem0[8]), 64'hCAFE);
        chk("abort_mem9", 64'(mem0[9]), 64'hAAEF);
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, a, e, cec);
        chk("post_abort_rdata", 64'(rd), 64'hCAFEAAEF);
        chk("post_abort_lat", 64'(lat), 64'd5);

        // Reset while the low half of a write is in its access cycle.
        @(negedge clk);
        wb_adr = 32'h20; wb_dat = 32'h11112222; wb_sel = 4'hF; wb_we = 1'b1;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("l_acc_state", 64'({ce_n[0], we_n[0], oe_n[0], addr0}), 64'({1'b0, 1'b0, 1'b1, 18'd17}));
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl", 64'({ce_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0], ack[0]}), 64'h3E);
        chk("rst_mid_addr", 64'(addr0), 64'h0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, a, e, cec);
        chk("post_rst_rdata", 64'(rd), 64'hCAFEAAEF);
        chk("post_rst_lat", 64'(lat), 64'd5);

        xfer(1'b0, 1'b1, 32'h0010_0000, 32'h0, 4'hF, rd, lat, a, e, cec);
`ifdef SRAM_ADDR_CHECK_EN
        chk("range_err", 64'(e), 64'h1);
        chk("range_no_ack", 64'(a), 64'h0);
        chk("range_err_lat", 64'(lat), 64'd1);
        chk("range_ce_idle", 64'(cec), 64'd0);
`else
        chk("alias_ack", 64'(a), 64'h1);
        chk("alias_no_err", 64'(e), 64'h0);
        chk("alias_lat", 64'(lat), 64'd5);
`endif

        // Three wait cycles per half.
        xfer(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, a, e, cec);
        chk("w3_write_lat", 64'(lat), 64'd9);
        chk("w3_mem8", 64'(mem1[8]), 64'hDEAD);
        chk("w3_mem9", 64'(mem1[9]), 64'hBEEF);
        xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, a, e, cec);
        chk("w3_read_lat", 64'(lat), 64'd9);
        chk("w3_rdata", 64'(rd), 64'hDEADBEEF);
        chk("w3_oe_runs", 64'(n_runs1), 64'd2);
        chk("w3_oe_run_h", 64'(prev_run1), 64'd3);
        chk("w3_oe_run_l", 64'(last_run1), 64'd3);
        chk("oe_we_overlap", 64'(bad_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
